// File: rtl/shift_reg_pkg.sv
// =============================================================================
// shift_reg_pkg: types shared by the shift-register serializer and deserializer
// Rev 1.0
// =============================================================================
`default_nettype none

package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } mode_t;

  // Prefixed so the literals do not collide with mode_t::HOLD
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_HOLD   = 2'd2,
    S_PARITY = 2'd3
  } deser_state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/deser_bit_counter.sv
// =============================================================================
// deser_bit_counter: counts received bits, flags the WIDTH-th bit and wraps
// Rev 1.0
// =============================================================================
`default_nettype none

module deser_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o = inc_i && !clear_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_deser.sv
// =============================================================================
// shift_reg_deser: framed serial-to-parallel receiver with valid/ready output.
// Optional trailing even-parity bit: define SHIFT_REG_DESER_PARITY_EN.
// Rev 1.0
// =============================================================================
`default_nettype none

module shift_reg_deser
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             s_valid,
  input  logic             s_in,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             is_zero,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  deser_state_t     state_q;
  dir_t             dir_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] p_out_q;
  logic             p_valid_q;
  logic             is_zero_q;
  logic             overrun_q;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_tc;

  assign shift_d = (dir_q == DIR_LEFT) ? {sreg_q[WIDTH-2:0], s_in}
                                       : {s_in, sreg_q[WIDTH-1:1]};

  // A start in HOLD only begins a new frame when the word is consumed too
  assign cnt_clear = start && ((state_q != S_HOLD) || p_ready);
  assign cnt_inc   = (state_q == S_RECV) && s_valid && !start;

  deser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .tc_o    (cnt_tc)
  );

`ifdef SHIFT_REG_DESER_PARITY_EN
  logic parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_LEFT;
      sreg_q    <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      is_zero_q <= 1'b1;
      overrun_q <= 1'b0;
`ifdef SHIFT_REG_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RECV;
            dir_q   <= dir_t'(dir);
            sreg_q  <= '0;
          end
        end
        S_RECV: begin
          if (start) begin
            dir_q  <= dir_t'(dir);
            sreg_q <= '0;
          end else if (s_valid) begin
            sreg_q <= shift_d;
            if (cnt_tc) begin
`ifdef SHIFT_REG_DESER_PARITY_EN
              state_q <= S_PARITY;
`else
              p_out_q   <= shift_d;
              p_valid_q <= 1'b1;
              is_zero_q <= (shift_d == '0);
              state_q   <= S_HOLD;
`endif
            end
          end
        end
`ifdef SHIFT_REG_DESER_PARITY_EN
        S_PARITY: begin
          if (start) begin
            state_q <= S_RECV;
            dir_q   <= dir_t'(dir);
            sreg_q  <= '0;
          end else if (s_valid) begin
            p_out_q      <= sreg_q;
            p_valid_q    <= 1'b1;
            is_zero_q    <= (sreg_q == '0);
            parity_err_q <= ^{sreg_q, s_in};
            state_q      <= S_HOLD;
          end
        end
`endif
        S_HOLD: begin
          if (s_valid) begin
            overrun_q <= 1'b1;
          end
          if (p_ready) begin
            p_valid_q <= 1'b0;
            if (start) begin
              state_q <= S_RECV;
              dir_q   <= dir_t'(dir);
              sreg_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (start) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign is_zero = is_zero_q;
  assign overrun = overrun_q;
  assign busy    = (state_q == S_RECV) || (state_q == S_PARITY);

`ifdef SHIFT_REG_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
